serial_alu_sequencer: RTL and testbench
=======================================

Name: serial_alu_sequencer

Overview:
- Controller that drives one Serialized_ALU through complete operations.
- Accepts a command over a valid/ready handshake and generates alu_sel, count, reg_write and the per-bit register-file index.
- For multiply, runs LENGTH radix-2 Booth iterations: an add/sub/no-op serial pass, then an arithmetic shift of the accumulator/multiplier register.
- Sits between the array-processor instruction decoder and the ALU plus its serial register files.

Parameters:
- LENGTH, 32, operand width in bits; legal range 2..62 so that 2*LENGTH+2 fits in count.
- CNT_W, 7, width of count; must match the ALU count port.
- IDX_W, 5, width of bit_idx; equals clog2(LENGTH).

Ports:
- clk  in  1  single clock; every register updates on posedge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  operation: 00 ADD, 01 SUB, 10 MUL, 11 AND.
- q_lsb  in  1  current LSB of the multiplier (Q) register; used only for MUL.
- alu_sel  out  4  ALU_Sel to the ALU.
- count  out  CNT_W  count to the ALU.
- reg_write  out  1  high while serial result bits are valid.
- bit_idx  out  IDX_W  operand/result bit index during SERIAL.
- booth_q1  out  1  ALU q1; holds Q0 of the current iteration.
- booth_q0  out  1  ALU q0; holds Q-1 (the previous Q0).
- shift_en  out  1  one-cycle pulse: arithmetic-shift the {A,Q} pair right by 1.
- busy  out  1  an operation is in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset is synchronous and active-high. When applied it forces: state IDLE, cmd_ready=1, alu_sel=4'd8, count=0, reg_write=0, bit_idx=0, booth_q1=0, booth_q0=0, shift_en=0, busy=0, done=0. Any operation in flight is abandoned; nothing is replayed.
- alu_sel mapping: ADD→0, SUB→1, MUL→2, AND→4. The idle value 8 matches no ALU case, so the ALU holds its state.
- Accept: a command is accepted on the posedge where cmd_valid && cmd_ready. That edge is cycle 0. cmd_op is latched and the iteration counter and booth_q0 are cleared.
- cmd_ready=1 only in IDLE. cmd_valid outside IDLE is ignored, and no command is queued.
- States: IDLE→SETUP→SERIAL→CLEAR→(SHIFT if MUL)→…→DONE→IDLE.
- SETUP (2 cycles):
  - count = 1, then 2; reg_write=0; alu_sel = the latched op's code.
  - On entry to the first SETUP cycle, booth_q1 <= q_lsb.
- SERIAL (LENGTH cycles):
  - count = 3..LENGTH+2; reg_write=1; bit_idx = count-3, running 0..LENGTH-1, LSB first.
- CLEAR (1 cycle):
  - count = 2*LENGTH+2, which clears the ALU carry/borrow; reg_write=0.
- SHIFT (1 cycle, MUL only):
  - shift_en=1 and booth_q0 <= booth_q1.
  - The iteration counter increments. If it reaches LENGTH, go to DONE; otherwise go to SETUP.
- Non-MUL ops make exactly one pass, then CLEAR→DONE.
- DONE (1 cycle): done=1, busy=0; next state IDLE.
- busy=1 in every state except IDLE and DONE.
- Latency:
  - ADD/SUB/AND: done is asserted in cycle LENGTH+4 (36 at default).
  - MUL: done is asserted in cycle LENGTH*(LENGTH+4)+1 (1153 at default).
- Outputs are registered, with no combinational path from input to output.
- Boundaries:
  - booth_q1/booth_q0 are stable for the whole of SETUP..CLEAR of an iteration.
  - An iteration counter wrap is impossible: DONE is forced at LENGTH.
  - reset asserted in the same cycle as an accept: reset wins.
  - cmd_valid held high through DONE: the next command is accepted in the first IDLE cycle, i.e. a back-to-back accept costs 1 IDLE cycle.

Decomposition:
- Shared package serial_alu_pkg holds:
  - op encodings OP_ADD/OP_SUB/OP_MUL/OP_AND;
  - ALU select constants ALU_ADD=0, ALU_SUB=1, ALU_MUL=2, ALU_AND=4, ALU_IDLE=8;
  - the state enum;
  - count landmarks SETUP_LAST=2, SERIAL_FIRST=3, CLR_CNT(LENGTH)=2*LENGTH+2.
- One sub-module, serial_pass_counter: generates count, bit_idx and reg_write for a single pass; start in, pass_done out.
- The FSM and Booth bookkeeping stay in the top module.

Test Plan:
- ADD accepted at cycle 0 → reg_write high for cycles 3..34 with bit_idx 0..31, count=66 at cycle 35, done=1 at cycle 36, cmd_ready=1 at cycle 37.
- SUB and AND → alu_sel=1 and alu_sel=4 respectively throughout SETUP..CLEAR, same timing as ADD; alu_sel=8 in IDLE.
- MUL with LENGTH=4, q_lsb sequence per iteration 1,0,1,1 → (booth_q1, booth_q0) = (1,0),(0,1),(1,0),(1,1); shift_en pulses at cycles 8,16,24,32; done at cycle 33.
- cmd_valid held high during a busy ADD with cmd_op=MUL → no accept until IDLE, MUL accepted at cycle 37, alu_sel=2 from cycle 38.
- reset pulsed for 1 cycle at cycle 500 of a MUL → next cycle all outputs at their reset values, no done pulse, cmd_ready=1.
- cmd_valid and reset high on the same edge → no accept, busy stays 0.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared encodings for the serial ALU sequencer: op codes, ALU selects,
// FSM states and count landmarks of a single serial pass.
package serial_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_MUL  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd4;
  // Matches no ALU case, so the ALU holds its state.
  localparam logic [3:0] ALU_IDLE = 4'd8;

  localparam int SETUP_LAST   = 2;
  localparam int SERIAL_FIRST = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SERIAL,
    ST_CLEAR,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // Count value that makes the ALU clear its carry/borrow.
  function automatic int clr_cnt(input int len);
    return 2 * len + 2;
  endfunction

  function automatic logic [3:0] alu_code(input logic [1:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_MUL:  return ALU_MUL;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/serial_pass_counter.sv
// Count generator for one serial pass: 1,2 (setup), 3..LENGTH+2 (serial),
// then the clear value, then back to 0. reg_write/bit_idx are registered
// alongside count so all three line up in the same cycle.
module serial_pass_counter
  import serial_alu_pkg::*;
#(
  parameter int LENGTH = 32,
  parameter int CNT_W  = 7,
  parameter int IDX_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [CNT_W-1:0] count,
  output logic [IDX_W-1:0] bit_idx,
  output logic             reg_write,
  output logic             pass_done
);

  localparam logic [CNT_W-1:0] SER_FIRST = CNT_W'(SERIAL_FIRST);
  localparam logic [CNT_W-1:0] SER_LAST  = CNT_W'(LENGTH + 2);
  localparam logic [CNT_W-1:0] CLR       = CNT_W'(clr_cnt(LENGTH));

  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] idx_full;
  logic             ser_nxt;

  // Next count: load 1 on start, walk up through setup/serial, jump to clear, drop to 0.
  always_comb begin
    cnt_nxt = '0;
    if (start)
      cnt_nxt = CNT_W'(1);
    else if (count != '0 && count < SER_LAST)
      cnt_nxt = count + CNT_W'(1);
    else if (count == SER_LAST)
      cnt_nxt = CLR;
    ser_nxt  = (cnt_nxt >= SER_FIRST) && (cnt_nxt <= SER_LAST);
    idx_full = cnt_nxt - SER_FIRST;
  end

  // Registered count, write strobe and LSB-first bit index.
  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      reg_write <= 1'b0;
      bit_idx   <= '0;
    end else begin
      count     <= cnt_nxt;
      reg_write <= ser_nxt;
      bit_idx   <= ser_nxt ? idx_full[IDX_W-1:0] : '0;
    end
  end

  assign pass_done = (count == CLR);

endmodule

// File: rtl/serial_alu_sequencer.sv
// Sequencer driving one serialized ALU: accepts a command, runs one serial
// pass (ADD/SUB/AND) or LENGTH radix-2 Booth iterations (MUL).
// All outputs are registered from the next state so they match the state
// of the cycle they appear in.
module serial_alu_sequencer
  import serial_alu_pkg::*;
#(
  parameter int LENGTH = 32,
  parameter int CNT_W  = 7,
  parameter int IDX_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             q_lsb,
  output logic [3:0]       alu_sel,
  output logic [CNT_W-1:0] count,
  output logic             reg_write,
  output logic [IDX_W-1:0] bit_idx,
  output logic             booth_q1,
  output logic             booth_q0,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] SER_LAST  = CNT_W'(LENGTH + 2);
  localparam logic [CNT_W-1:0] SET_LAST  = CNT_W'(SETUP_LAST);
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(LENGTH - 1);

  state_e           state, state_nxt;
  logic [1:0]       op, op_nxt;
  logic [CNT_W-1:0] iter;
  logic             accept, start, pass_done;

  serial_pass_counter #(
    .LENGTH(LENGTH), .CNT_W(CNT_W), .IDX_W(IDX_W)
  ) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .count     (count),
    .bit_idx   (bit_idx),
    .reg_write (reg_write),
    .pass_done (pass_done)
  );

  // Next state; start restarts the pass counter for a new (Booth) iteration.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    accept    = 1'b0;
    unique case (state)
      ST_IDLE:
        if (cmd_valid) begin
          state_nxt = ST_SETUP;
          start     = 1'b1;
          accept    = 1'b1;
        end
      ST_SETUP:  if (count == SET_LAST) state_nxt = ST_SERIAL;
      ST_SERIAL: if (count == SER_LAST) state_nxt = ST_CLEAR;
      ST_CLEAR:  if (pass_done) state_nxt = (op == OP_MUL) ? ST_SHIFT : ST_DONE;
      ST_SHIFT:
        if (iter == ITER_LAST) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_SETUP;
          start     = 1'b1;
        end
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    op_nxt = accept ? cmd_op : op;
  end

  // State, Booth bookkeeping and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      op        <= OP_ADD;
      iter      <= '0;
      cmd_ready <= 1'b1;
      alu_sel   <= ALU_IDLE;
      booth_q1  <= 1'b0;
      booth_q0  <= 1'b0;
      shift_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
      if (state == ST_SHIFT) iter <= iter + CNT_W'(1);
      if (accept) begin
        iter     <= '0;
        booth_q0 <= 1'b0;
      end
      // Q0 of the new iteration is captured on entry to its first setup cycle.
      if (start) booth_q1 <= q_lsb;
      // Q-1 takes the retiring Q0 as the pair shifts.
      if (state_nxt == ST_SHIFT) booth_q0 <= booth_q1;
      cmd_ready <= (state_nxt == ST_IDLE);
      busy      <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
      done      <= (state_nxt == ST_DONE);
      shift_en  <= (state_nxt == ST_SHIFT);
      alu_sel   <= (state_nxt == ST_SETUP || state_nxt == ST_SERIAL || state_nxt == ST_CLEAR)
                   ? alu_code(op_nxt) : ALU_IDLE;
    end
  end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Randomized bench for serial_alu_sequencer: the expected outputs of every
// cycle are derived from the position in the operation timeline.
module tb_serial_alu_sequencer;

  localparam int L     = 32;
  localparam int CNT_W = 7;
  localparam int IDX_W = 5;
  localparam int PER   = L + 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             q_lsb;
  logic [3:0]       alu_sel;
  logic [CNT_W-1:0] count;
  logic             reg_write;
  logic [IDX_W-1:0] bit_idx;
  logic             booth_q1, booth_q0, shift_en, busy, done;

  int n_chk  = 0;
  int n_pass = 0;

  serial_alu_sequencer #(.LENGTH(L), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .q_lsb(q_lsb), .alu_sel(alu_sel), .count(count),
    .reg_write(reg_write), .bit_idx(bit_idx), .booth_q1(booth_q1),
    .booth_q0(booth_q0), .shift_en(shift_en), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  function automatic int exp_sel(input logic [1:0] op);
    case (op)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b10:   return 2;
      default: return 4;
    endcase
  endfunction

  task automatic chk_rst(input string tag);
    chk({tag, ".ready"}, int'(cmd_ready), 1);
    chk({tag, ".sel"},   int'(alu_sel),   8);
    chk({tag, ".cnt"},   int'(count),     0);
    chk({tag, ".rw"},    int'(reg_write), 0);
    chk({tag, ".idx"},   int'(bit_idx),   0);
    chk({tag, ".q1"},    int'(booth_q1),  0);
    chk({tag, ".q0"},    int'(booth_q0),  0);
    chk({tag, ".shf"},   int'(shift_en),  0);
    chk({tag, ".busy"},  int'(busy),      0);
    chk({tag, ".done"},  int'(done),      0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ready"}, int'(cmd_ready), 1);
    chk({tag, ".busy"},  int'(busy),      0);
    chk({tag, ".done"},  int'(done),      0);
    chk({tag, ".sel"},   int'(alu_sel),   8);
    chk({tag, ".rw"},    int'(reg_write), 0);
    chk({tag, ".shf"},   int'(shift_en),  0);
  endtask

  // Called in an IDLE cycle. Runs one command from accept to the edge after
  // DONE. While busy, cmd_valid/cmd_op are held at bv/bop (must be ignored).
  // abort_at>0 pulses reset in that cycle of the timeline.
  task automatic do_op(input logic [1:0] op, input logic bv, input logic [1:0] bop,
                       input int abort_at);
    bit qs[$];
    int tot, p, k, sel, ecnt, erw;
    tot = (op == 2'b10) ? L * PER + 1 : PER;
    sel = exp_sel(op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    q_lsb     = 1'($urandom_range(0, 1));
    qs.push_back(q_lsb);
    @(negedge clk);
    chk_idle("acc");
    @(posedge clk); #1;
    for (int t = 1; t <= tot; t++) begin
      cmd_valid = bv;
      cmd_op    = bop;
      q_lsb     = 1'($urandom_range(0, 1));
      if (t == abort_at) reset = 1'b1;
      k = (t - 1) / PER;
      p = (t - 1) % PER + 1;
      if (op == 2'b10 && p == PER) qs.push_back(q_lsb);
      @(negedge clk);
      if (t == tot) begin
        chk("done", int'(done), 1);
        chk("done.busy", int'(busy), 0);
        chk("done.ready", int'(cmd_ready), 0);
      end else begin
        chk("busy", int'(busy), 1);
        chk("nodone", int'(done), 0);
        chk("ready", int'(cmd_ready), 0);
        if (p <= L + 3) begin
          ecnt = (p <= L + 2) ? p : 2 * L + 2;
          erw  = (p >= 3 && p <= L + 2) ? 1 : 0;
          chk("sel", int'(alu_sel), sel);
          chk("cnt", int'(count), ecnt);
          chk("rw", int'(reg_write), erw);
          if (erw == 1) chk("idx", int'(bit_idx), p - 3);
          chk("shf", int'(shift_en), 0);
          if (op == 2'b10) begin
            chk("q1", int'(booth_q1), int'(qs[k]));
            chk("q0", int'(booth_q0), (k == 0) ? 0 : int'(qs[k-1]));
          end
        end else begin
          chk("shf", int'(shift_en), 1);
        end
      end
      @(posedge clk); #1;
      if (t == abort_at) begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk_rst("abort");
        @(posedge clk); #1;
        return;
      end
    end
  endtask

  initial begin
    logic [1:0] nop, bop;
    logic       bv, carry;
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] nop, bop;
    logic       bv, carry;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; q_lsb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_rst("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_idle("idle0");
    @(posedge clk); #1;

    // Directed ops, then back-to-back MUL held on cmd_valid during a busy ADD.
    do_op(2'b00, 1'b0, 2'b00, 0);
    cmd_valid = 1'b0;
    @(negedge clk); chk_idle("idle1"); @(posedge clk); #1;
    do_op(2'b01, 1'b0, 2'b00, 0);
    do_op(2'b11, 1'b0, 2'b00, 0);
    do_op(2'b00, 1'b1, 2'b10, 0);
    do_op(2'b10, 1'b0, 2'b00, 0);

    // Random commands, gaps and busy-time cmd_valid noise.
    carry = 1'b0;
    nop   = 2'b00;
    repeat (6) begin
      if (!carry) begin
        nop = 2'($urandom_range(0, 3));
        cmd_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk); chk_idle("gap"); @(posedge clk); #1;
        end
      end
      bv  = 1'($urandom_range(0, 1));
      bop = 2'($urandom_range(0, 3));
      do_op(nop, bv, bop, 0);
      carry = bv;
      nop   = bop;
    end
    cmd_valid = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of a multiply: abandoned, no done pulse.
    do_op(2'b10, 1'b0, 2'b00, 500);
    repeat (3) begin
      @(negedge clk);
      chk("post.done", int'(done), 0);
      chk("post.busy", int'(busy), 0);
      chk("post.ready", int'(cmd_ready), 1);
      @(posedge clk); #1;
    end

    // Reset and cmd_valid on the same edge: reset wins.
    cmd_valid = 1'b1; cmd_op = 2'b10; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("rv.busy", int'(busy), 0);
    chk("rv.sel", int'(alu_sel), 8);
    chk("rv.ready", int'(cmd_ready), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rv.busy2", int'(busy), 0);
    @(posedge clk); #1;

    do_op(2'b00, 1'b0, 2'b00, 0);
    cmd_valid = 1'b0;
    @(negedge clk); chk_idle("end"); @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
